// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: bundle of ID reads (src/reg/hazard), ID issue, WB write, flush and sticky error; master=pipeline, slave=regfile
interface regfile_scoreboard_if #(parameter int DATA_W = 32, parameter int ADDR_W = 5);
  logic [ADDR_W-1:0] src1, src2, issue_dest, wb_dest;
  logic [DATA_W-1:0] reg1, reg2, wb_value;
  logic issue_en, wb_en, sb_clear, hazard1, hazard2, sb_err;
  modport master(
    output src1, src2, issue_en, issue_dest, wb_en, wb_dest, wb_value, sb_clear,
    input reg1, reg2, hazard1, hazard2, sb_err
  );
  modport slave(
    input src1, src2, issue_en, issue_dest, wb_en, wb_dest, wb_value, sb_clear,
    output reg1, reg2, hazard1, hazard2, sb_err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2-read/1-write register file with write-through bypass and per-register pending-write counters (ports: clk, rst async active-low, bus slave)
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG = 32,
  parameter int CNT_W = 2
) (
  input logic clk,
  input logic rst,
  regfile_scoreboard_if.slave bus
);
  logic [DATA_W-1:0] mem [NREG];
  logic [CNT_W-1:0] pend [NREG];
  logic [NREG-1:0] inc, dec, ovf, unf;
  logic sb_err_q, dec1, dec2;
  always_comb begin
    inc = '0;
    dec = '0;
    ovf = '0;
    unf = '0;
    for (int i = 1; i < NREG; i++) begin
      inc[i] = bus.issue_en && bus.issue_dest == ADDR_W'(i);
      dec[i] = bus.wb_en && bus.wb_dest == ADDR_W'(i);
      ovf[i] = inc[i] && !dec[i] && pend[i] == '1;
      unf[i] = dec[i] && !inc[i] && pend[i] == '0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
        pend[i] <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      if (bus.wb_en && bus.wb_dest != '0) mem[bus.wb_dest] <= bus.wb_value;
      for (int i = 1; i < NREG; i++)
        pend[i] <= bus.sb_clear ? '0 :
                   (inc[i] && !dec[i] && !ovf[i]) ? pend[i] + 1'b1 :
                   (dec[i] && !inc[i] && !unf[i]) ? pend[i] - 1'b1 : pend[i];
      if (|(ovf | unf)) sb_err_q <= 1'b1;
    end
  end
  // a retiring write this cycle is forwarded by the bypass, so it no longer counts as pending
  assign dec1 = bus.wb_en && bus.wb_dest == bus.src1;
  assign dec2 = bus.wb_en && bus.wb_dest == bus.src2;
  assign bus.reg1 = (!rst || bus.src1 == '0) ? '0 : dec1 ? bus.wb_value : mem[bus.src1];
  assign bus.reg2 = (!rst || bus.src2 == '0) ? '0 : dec2 ? bus.wb_value : mem[bus.src2];
  assign bus.hazard1 = rst && bus.src1 != '0 && pend[bus.src1] > CNT_W'(dec1);
  assign bus.hazard2 = rst && bus.src2 != '0 && pend[bus.src2] > CNT_W'(dec2);
  assign bus.sb_err = sb_err_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed vectors into an expectation queue, checked by an independent negedge monitor
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) bus();
  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NREG(32), .CNT_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    string nm;
    logic [31:0] r1, r2;
    logic h1, h2, err;
  } exp_t;
  exp_t q[$];
  int vecs = 0;
  int errs = 0;
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      vecs++;
      if (bus.reg1 !== e.r1 || bus.reg2 !== e.r2 || bus.hazard1 !== e.h1 ||
          bus.hazard2 !== e.h2 || bus.sb_err !== e.err) begin
        errs++;
        $display("FAIL %s: got r1=%h r2=%h h1=%b h2=%b err=%b, need r1=%h r2=%h h1=%b h2=%b err=%b",
                 e.nm, bus.reg1, bus.reg2, bus.hazard1, bus.hazard2, bus.sb_err,
                 e.r1, e.r2, e.h1, e.h2, e.err);
      end
    end
  end
  task automatic cyc(input string nm, input logic rn, input logic [4:0] s1, s2,
                     input logic ie, input logic [4:0] id, input logic we,
                     input logic [4:0] wd, input logic [31:0] wv, input logic clr,
                     input logic [31:0] e1, e2, input logic eh1, eh2, eerr);
    exp_t e;
    @(posedge clk);
    #1;
    rst = rn;
    bus.src1 = s1;
    bus.src2 = s2;
    bus.issue_en = ie;
    bus.issue_dest = id;
    bus.wb_en = we;
    bus.wb_dest = wd;
    bus.wb_value = wv;
    bus.sb_clear = clr;
    e.nm = nm;
    e.r1 = e1;
    e.r2 = e2;
    e.h1 = eh1;
    e.h2 = eh2;
    e.err = eerr;
    q.push_back(e);
  endtask
  initial begin
    bus.src1 = '0;
    bus.src2 = '0;
    bus.issue_en = 1'b0;
    bus.issue_dest = '0;
    bus.wb_en = 1'b0;
    bus.wb_dest = '0;
    bus.wb_value = '0;
    bus.sb_clear = 1'b0;
    #1 rst = 1'b0;
    cyc("rst_gate_bypass", 0, 5, 31, 0, 0, 1, 5, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
    cyc("rst_hold",        0, 5, 31, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0);
    cyc("read_after_rst",  1, 5, 31, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0);
    cyc("issue7",          1, 7, 0, 1, 7, 0, 0, 0, 0,              0, 0, 0, 0, 0);
    cyc("bypass7",         1, 7, 7, 0, 0, 1, 7, 32'hDEADBEEF, 0,   32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
    cyc("stored7",         1, 7, 0, 0, 0, 0, 0, 0, 0,              32'hDEADBEEF, 0, 0, 0, 0);
    cyc("reg0_ops",        1, 0, 0, 1, 0, 1, 0, 32'h1234, 0,       0, 0, 0, 0, 0);
    cyc("reg0_after",      1, 0, 0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0);
    cyc("issue3_a",        1, 3, 0, 1, 3, 0, 0, 0, 0,              0, 0, 0, 0, 0);
    cyc("issue3_b",        1, 3, 0, 1, 3, 0, 0, 0, 0,              0, 0, 1, 0, 0);
    cyc("wb3_first",       1, 3, 0, 0, 0, 1, 3, 32'hA, 0,          32'hA, 0, 1, 0, 0);
    cyc("wb3_last",        1, 3, 0, 0, 0, 1, 3, 32'hB, 0,          32'hB, 0, 0, 0, 0);
    cyc("read3",           1, 3, 0, 0, 0, 0, 0, 0, 0,              32'hB, 0, 0, 0, 0);
    cyc("issue4",          1, 0, 4, 1, 4, 0, 0, 0, 0,              0, 0, 0, 0, 0);
    cyc("issue_wb4",       1, 0, 4, 1, 4, 1, 4, 32'h44, 0,         0, 32'h44, 0, 0, 0);
    cyc("pend4_held",      1, 0, 4, 0, 0, 0, 0, 0, 0,              0, 32'h44, 0, 1, 0);
    cyc("issue9_1",        1, 9, 0, 1, 9, 0, 0, 0, 0,              0, 0, 0, 0, 0);
    cyc("issue9_2",        1, 9, 0, 1, 9, 0, 0, 0, 0,              0, 0, 1, 0, 0);
    cyc("issue9_3",        1, 9, 0, 1, 9, 0, 0, 0, 0,              0, 0, 1, 0, 0);
    cyc("issue9_4",        1, 9, 0, 1, 9, 0, 0, 0, 0,              0, 0, 1, 0, 0);
    cyc("clear_cycle",     1, 9, 0, 0, 0, 0, 0, 0, 1,              0, 0, 1, 0, 1);
    cyc("after_clear",     1, 9, 4, 0, 0, 0, 0, 0, 0,              0, 32'h44, 0, 0, 1);
    cyc("issue5",          1, 5, 0, 1, 5, 0, 0, 0, 0,              0, 0, 0, 0, 1);
    cyc("rst_mid_a",       0, 5, 7, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0);
    cyc("rst_rel_a",       1, 5, 7, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0);
    cyc("underflow12",     1, 12, 0, 0, 0, 1, 12, 32'hC0FFEE, 0,  32'hC0FFEE, 0, 0, 0, 0);
    cyc("after_unf12",     1, 12, 0, 0, 0, 0, 0, 0, 0,             32'hC0FFEE, 0, 0, 0, 1);
    cyc("rst_mid_b",       0, 12, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0);
    cyc("rst_rel_b",       1, 12, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d pending, need 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Register file plus write-back scoreboard. It is the responder that serves the ID stage's two operand reads, and it accepts the single write port driven by the WB stage.
- It tracks in-flight destination writes per register, so ID can stall on RAW hazards that forwarding cannot cover.
- Sits between ID_stage (read/issue side) and the WB stage (write side) of the 5-stage MIPS pipeline.

Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register index width
- NREG, 32, number of architectural registers (2**ADDR_W)
- CNT_W, 2, width of per-register pending counter (max 3 in-flight writes to one register)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous reset, active-low
- src1  input  ADDR_W  ID read address, port 1
- src2  input  ADDR_W  ID read address, port 2
- reg1  output  DATA_W  read data, port 1
- reg2  output  DATA_W  read data, port 2
- issue_en  input  1  ID issues an instruction that will write back
- issue_dest  input  ADDR_W  destination of issued instruction
- wb_en  input  1  WB stage write enable
- wb_dest  input  ADDR_W  WB destination register
- wb_value  input  DATA_W  WB write data
- sb_clear  input  1  synchronous clear of all pending counters (pipeline flush)
- hazard1  output  1  src1 has an unretired pending write
- hazard2  output  1  src2 has an unretired pending write
- sb_err  output  1  sticky error: counter overflow or underflow

Behaviour:
- Reset (rst=0, asynchronous): all registers = 0, all pending counters = 0, sb_err = 0. Outputs reg1/reg2 = 0 and hazard1/hazard2 = 0 while in reset.
- Register 0 is hardwired to 0.
  - Reads of index 0 return 0.
  - Writes to 0 are dropped.
  - issue_en to 0 and wb_en to 0 do not touch any counter.
- Reads are combinational, zero latency.
- Write-through bypass: if wb_en && wb_dest==srcN && srcN!=0, regN = wb_value in the same cycle. Otherwise regN = stored value.
- Write: on rising edge with wb_en && wb_dest!=0, mem[wb_dest] <= wb_value.
- Pending counter pend[r] per register r != 0, evaluated on each rising edge:
  - inc = issue_en && issue_dest==r
  - dec = wb_en && wb_dest==r
  - inc && !dec: pend+1. If pend was 3: hold at 3, set sb_err.
  - dec && !inc: pend-1. If pend was 0: hold at 0, set sb_err.
  - inc && dec: unchanged. No error, including at 0 or 3.
  - sb_clear: all pend <= 0, overriding inc/dec in the same cycle. sb_err is not cleared; only reset clears it.
- Hazard (combinational): hazardN = (srcN!=0) && (pend[srcN] - dec_now(srcN) > 0).
  - dec_now is 1 when wb_en && wb_dest==srcN that cycle, so a final retire in the same cycle is covered by the bypass and raises no hazard.
  - The same-cycle issue_en does not affect hazardN; only the registered count does.
  - sb_clear does not mask hazards in its own cycle; the effect is visible next cycle.
- sb_err is sticky from the first error until reset.
- Reset asserted mid-operation: all state clears immediately; there is no partial-write requirement.
- No X on outputs for any in-range input once out of reset.

Test Plan:
- Reset then read: rst=0 for 2 cycles, release, src1=5, src2=31 -> reg1=0, reg2=0, hazard1=hazard2=0, sb_err=0.
- Write/read and bypass: wb_en=1, wb_dest=7, wb_value=0xDEADBEEF, src1=7 in the same cycle -> reg1=0xDEADBEEF that cycle. Next cycle wb_en=0 -> reg1 still 0xDEADBEEF.
- Register 0: wb_en=1, wb_dest=0, wb_value=0x1234; issue_en=1, issue_dest=0; src1=0 -> reg1=0 always, hazard1=0, no counter change, sb_err=0.
- Scoreboard: issue_dest=3 on 2 consecutive cycles -> pend[3]=2, hazard1=1 with src1=3.
  - First wb to 3 (value 0xA) -> hazard1 still 1.
  - Second wb to 3 (value 0xB) -> hazard1=0 during that cycle, reg1=0xB.
- Simultaneous events and overflow:
  - issue and wb to reg 4 same cycle with pend[4]=1 -> pend stays 1, hazard continues.
  - 4 issues to reg 9 -> pend=3, sb_err=1 after 4th edge.
  - sb_clear -> hazard on 9 drops next cycle; sb_err stays 1.
- Underflow and mid-op reset: wb_en to reg 12 with pend[12]=0 -> write occurs, sb_err=1. Assert rst mid-cycle -> sb_err, reg12, and all pend go to 0 immediately.
